// File: rtl/running_sum_pkg.sv
// Shared mode encoding and saturating-add helper for the running window sum block.
package running_sum_pkg;

    typedef enum logic {
        MODE_CUMUL  = 1'b0,
        MODE_WINDOW = 1'b1
    } mode_e;

    // Working width of sat_add; callers zero-extend into it and truncate the result back.
    localparam int unsigned SAT_W = 32;

    // Unsigned a + b clipped to 2**width - 1 (width <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
        if (sum > max_val) begin
            return max_val[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/running_window_sum_if.sv
// Stream bundle for running_window_sum: control/sample inputs and registered results.
// avg_out exists only when RUNNING_SUM_AVG_EN is defined.
interface running_window_sum_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 16
);
    logic              clr;
    logic              mode;
    logic              data_in_valid;
    logic [DATA_W-1:0] data_in;
    logic              data_out_valid;
    logic [OUT_W-1:0]  data_out;
    logic              win_full;
    logic              sat_flag;
`ifdef RUNNING_SUM_AVG_EN
    logic [DATA_W-1:0] avg_out;

    modport master (
        output clr, mode, data_in_valid, data_in,
        input  data_out_valid, data_out, win_full, sat_flag, avg_out
    );
    modport slave (
        input  clr, mode, data_in_valid, data_in,
        output data_out_valid, data_out, win_full, sat_flag, avg_out
    );
`else
    modport master (
        output clr, mode, data_in_valid, data_in,
        input  data_out_valid, data_out, win_full, sat_flag
    );
    modport slave (
        input  clr, mode, data_in_valid, data_in,
        output data_out_valid, data_out, win_full, sat_flag
    );
`endif
endinterface

// File: rtl/running_sum_delay_line.sv
// WIN-deep circular sample buffer: reports the sample about to be overwritten (0 until full)
// and whether the buffer will hold WIN samples after this cycle.
module running_sum_delay_line #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WIN_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] oldest_o,
    output logic              full_next_o
);
    localparam int unsigned         WIN        = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0]   COUNT_FULL = (WIN_LOG2+1)'(WIN);

    logic [DATA_W-1:0]   mem_q [WIN];
    logic [WIN_LOG2-1:0] ptr_q, ptr_d;
    logic [WIN_LOG2:0]   count_q, count_d;

    // Read happens before the same-edge write, so this is the sample leaving the window.
    assign oldest_o    = (count_q == COUNT_FULL) ? mem_q[ptr_q] : '0;
    assign full_next_o = (count_d == COUNT_FULL);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clr_i) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (wr_en_i) begin
            ptr_d = ptr_q + WIN_LOG2'(1);
            if (count_q != COUNT_FULL) begin
                count_d = count_q + (WIN_LOG2+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/running_window_sum.sv
// Streaming unsigned sum: saturating cumulative total or sliding sum of the last 2**WIN_LOG2 samples.
// Define RUNNING_SUM_AVG_EN to add the registered window average output avg_out.
module running_window_sum
    import running_sum_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned WIN_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    running_window_sum_if.slave bus
);
    generate
        if (WIN_LOG2 < 1) begin : g_bad_win
            $error("running_window_sum: WIN_LOG2 must be at least 1");
        end
        if (OUT_W < DATA_W + WIN_LOG2) begin : g_bad_out_w
            $error("running_window_sum: OUT_W must be at least DATA_W + WIN_LOG2");
        end
        if (OUT_W > SAT_W) begin : g_bad_sat_w
            $error("running_window_sum: OUT_W exceeds the saturating adder width");
        end
    endgenerate

    mode_e mode_in, mode_q;
    logic  mode_change, clear, accept, accept_win;

    logic [DATA_W-1:0] oldest;
    logic              full_next;
    logic [OUT_W:0]    cum_raw;
    logic [OUT_W-1:0]  cum_sat;

    logic [OUT_W-1:0]  sum_q, sum_d;
    logic              valid_q, valid_d;
    logic              win_full_q;
    logic              sat_q, sat_d;

    assign mode_in     = mode_e'(bus.mode);
    // A mode flip invalidates the running state, so it is handled exactly like clr.
    assign mode_change = (mode_in != mode_q);
    assign clear       = bus.clr | mode_change;
    assign accept      = bus.data_in_valid & ~clear;
    assign accept_win  = accept & (mode_q == MODE_WINDOW);

    running_sum_delay_line #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_delay_line (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clear),
        .wr_en_i     (accept_win),
        .wr_data_i   (bus.data_in),
        .oldest_o    (oldest),
        .full_next_o (full_next)
    );

    // The extra carry bit of the raw sum is exactly the clipping condition.
    assign cum_raw = {1'b0, sum_q} + (OUT_W+1)'(bus.data_in);
    assign cum_sat = OUT_W'(sat_add(SAT_W'(sum_q), SAT_W'(bus.data_in), OUT_W));

`ifdef RUNNING_SUM_AVG_EN
    logic [DATA_W-1:0] avg_q, avg_d;
`endif

    always_comb begin
        sum_d   = sum_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
`ifdef RUNNING_SUM_AVG_EN
        avg_d   = avg_q;
`endif
        if (clear) begin
            sum_d = '0;
            sat_d = 1'b0;
`ifdef RUNNING_SUM_AVG_EN
            avg_d = '0;
`endif
        end else if (accept) begin
            valid_d = 1'b1;
            if (mode_q == MODE_WINDOW) begin
                // Width rule guarantees the window sum never wraps.
                sum_d = sum_q + OUT_W'(bus.data_in) - OUT_W'(oldest);
`ifdef RUNNING_SUM_AVG_EN
                avg_d = DATA_W'(sum_d >> WIN_LOG2);
`endif
            end else begin
                sum_d = cum_sat;
                if (cum_raw[OUT_W]) begin
                    sat_d = 1'b1;
                end
`ifdef RUNNING_SUM_AVG_EN
                avg_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= mode_in;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            win_full_q <= 1'b0;
            sat_q      <= 1'b0;
`ifdef RUNNING_SUM_AVG_EN
            avg_q      <= '0;
`endif
        end else begin
            mode_q     <= mode_in;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            win_full_q <= full_next;
            sat_q      <= sat_d;
`ifdef RUNNING_SUM_AVG_EN
            avg_q      <= avg_d;
`endif
        end
    end

    assign bus.data_out       = sum_q;
    assign bus.data_out_valid = valid_q;
    assign bus.win_full       = win_full_q;
    assign bus.sat_flag       = sat_q;
`ifdef RUNNING_SUM_AVG_EN
    assign bus.avg_out        = avg_q;
`endif

endmodule

// File: tb/tb_running_window_sum.sv
// Self-checking bench for running_window_sum: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_running_window_sum;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OUT_W    = 10;
    localparam int unsigned WIN_LOG2 = 2;
    localparam int          WIN      = 4;
    localparam int          MAXV     = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;

    running_window_sum_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    running_window_sum #(
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: window contents held as a plain queue, cumulative total as an integer.
    int mq[$];
    int m_cum  = 0;
    int m_out  = 0;
    int m_avg  = 0;
    bit m_vld  = 0;
    bit m_full = 0;
    bit m_sat  = 0;
    bit m_prev_mode = 0;

    task automatic model_step(input bit r, input bit c, input bit md, input bit v, input int d);
        if (r || c || (md != m_prev_mode)) begin
            mq.delete();
            m_cum  = 0;
            m_out  = 0;
            m_avg  = 0;
            m_vld  = 0;
            m_full = 0;
            m_sat  = 0;
        end else if (v) begin
            m_vld = 1;
            if (md) begin
                mq.push_back(d);
                if (mq.size() > WIN) void'(mq.pop_front());
                m_out = 0;
                foreach (mq[i]) m_out += mq[i];
                m_full = (mq.size() == WIN);
                m_avg  = m_out / WIN;
            end else begin
                m_cum += d;
                if (m_cum > MAXV) begin
                    m_cum = MAXV;
                    m_sat = 1;
                end
                m_out = m_cum;
                m_avg = 0;
            end
        end else begin
            m_vld = 0;
        end
        m_prev_mode = md;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},    bus.data_out_valid, m_vld);
        check({tag, ".data_out"}, bus.data_out,       m_out);
        check({tag, ".win_full"}, bus.win_full,       m_full);
        check({tag, ".sat_flag"}, bus.sat_flag,       m_sat);
`ifdef RUNNING_SUM_AVG_EN
        check({tag, ".avg_out"},  bus.avg_out,        m_avg);
`endif
    endtask

    // Called at a negedge: drive, let one rising edge pass, then compare at the next negedge.
    task automatic cycle(input string tag, input bit r, input bit c, input bit md, input bit v, input int d);
        rst               = r;
        bus.clr           = c;
        bus.mode          = md;
        bus.data_in_valid = v;
        bus.data_in       = DATA_W'(d);
        @(posedge clk);
        model_step(r, c, md, v, d);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        int exp_w[6];
        int exp_c[5];
        bit md;

        bus.clr = 1'b0;
        bus.mode = 1'b1;
        bus.data_in_valid = 1'b0;
        bus.data_in = '0;
        @(negedge clk);

        // Reset state
        cycle("rst", 1, 0, 1, 1, 77);
        cycle("rst", 1, 0, 1, 0, 0);
        check("rst.data_out", bus.data_out, 0);
        check("rst.valid", bus.data_out_valid, 0);

        // Windowed fill and slide
        exp_w = '{1, 3, 6, 10, 14, 18};
        for (int i = 0; i < 6; i++) begin
            cycle("win", 0, 0, 1, 1, i + 1);
            check("win.spec_out", bus.data_out, exp_w[i]);
            check("win.spec_full", bus.win_full, (i >= 3) ? 1 : 0);
        end

        // Valid gaps
        cycle("gap_clr", 0, 1, 1, 0, 0);
        cycle("gap", 0, 0, 1, 1, 10);
        for (int i = 0; i < 3; i++) begin
            cycle("gap_idle", 0, 0, 1, 0, 99);
            check("gap.held", bus.data_out, 10);
        end
        cycle("gap", 0, 0, 1, 1, 20);
        check("gap.spec_out", bus.data_out, 30);

        // clr coincident with a valid sample
        cycle("clr_pre", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) cycle("clr_fill", 0, 0, 1, 1, i);
        cycle("clr_hit", 0, 1, 1, 1, 50);
        check("clr.spec_out", bus.data_out, 0);
        check("clr.spec_valid", bus.data_out_valid, 0);
        cycle("clr_after", 0, 0, 1, 1, 7);
        check("clr.spec_after", bus.data_out, 7);

        // Mode switch then reset mid-stream
        cycle("ms", 0, 0, 1, 1, 5);
        cycle("ms", 0, 0, 1, 1, 5);
        cycle("ms_switch", 0, 0, 0, 1, 9);
        check("ms.spec_drop", bus.data_out, 0);
        check("ms.spec_drop_valid", bus.data_out_valid, 0);
        cycle("ms_next", 0, 0, 0, 1, 9);
        check("ms.spec_next", bus.data_out, 9);
        cycle("ms_rst", 1, 0, 0, 0, 0);
        check("ms.spec_rst", bus.data_out, 0);

        // Cumulative saturation
        exp_c = '{255, 510, 765, 1020, 1023};
        for (int i = 0; i < 5; i++) begin
            cycle("cum", 0, 0, 0, 1, 255);
            check("cum.spec_out", bus.data_out, exp_c[i]);
            check("cum.spec_sat", bus.sat_flag, (i == 4) ? 1 : 0);
        end
        cycle("cum_hold", 0, 0, 0, 1, 0);
        check("cum.sticky", bus.sat_flag, 1);
        cycle("cum_clr", 0, 1, 0, 0, 0);
        check("cum.sat_cleared", bus.sat_flag, 0);

`ifdef RUNNING_SUM_AVG_EN
        begin
            int exp_a[5];
            exp_a = '{1, 3, 6, 10, 14};
            cycle("avg_rst", 1, 0, 1, 0, 0);
            for (int i = 0; i < 5; i++) begin
                cycle("avg", 0, 0, 1, 1, 4 * (i + 1));
                check("avg.spec_out", bus.avg_out, exp_a[i]);
            end
        end
`endif

        // Random traffic against the model
        md = 1'b1;
        cycle("rnd_rst", 1, 0, md, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, c, v;
            int d;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) md = ~md;
            d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            cycle("rnd", r, c, md, v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
